// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with byte-enable writes, registered reads,
// write-first and clear-first bypass, and a sequenced clear-all engine.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_vld_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_vld_b,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              wr_ok_s;
  logic [DATA_W-1:0] wr_word_s;
  logic [DATA_W-1:0] rd_word_a_s;
  logic [DATA_W-1:0] rd_word_b_s;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return ({{(32-ADDR_W){1'b0}}, addr} < 32'(DEPTH));
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Write acceptance and the merged word that the entry will hold after the edge
  always_comb begin
    wr_ok_s   = wr_en && !busy && addr_in_range(wr_addr);
    wr_word_s = merge_bytes(mem_r[wr_addr], wr_data, wr_be);
  end

  // Next read data per port: out-of-range and the entry being cleared read as
  // zero; a same-cycle accepted write is forwarded so reads see the new value
  always_comb begin
    if (!addr_in_range(rd_addr_a)) begin
      rd_word_a_s = {DATA_W{1'b0}};
    end else if (busy && (rd_addr_a == ptr_r)) begin
      rd_word_a_s = {DATA_W{1'b0}};
    end else if (wr_ok_s && (rd_addr_a == wr_addr)) begin
      rd_word_a_s = wr_word_s;
    end else begin
      rd_word_a_s = mem_r[rd_addr_a];
    end

    if (!addr_in_range(rd_addr_b)) begin
      rd_word_b_s = {DATA_W{1'b0}};
    end else if (busy && (rd_addr_b == ptr_r)) begin
      rd_word_b_s = {DATA_W{1'b0}};
    end else if (wr_ok_s && (rd_addr_b == wr_addr)) begin
      rd_word_b_s = wr_word_s;
    end else begin
      rd_word_b_s = mem_r[rd_addr_b];
    end
  end

  // Storage, clear sequencer and registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      state_r   <= IDLE;
      ptr_r     <= {ADDR_W{1'b0}};
      busy      <= 1'b0;
      rd_data_a <= {DATA_W{1'b0}};
      rd_vld_a  <= 1'b0;
      rd_data_b <= {DATA_W{1'b0}};
      rd_vld_b  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_addr] <= wr_word_s;
      end

      case (state_r)
        IDLE: begin
          if (clr_req) begin
            state_r <= CLEAR;
            ptr_r   <= {ADDR_W{1'b0}};
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          mem_r[ptr_r] <= {DATA_W{1'b0}};
          if (ptr_r == LAST_PTR) begin
            state_r <= IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            busy    <= 1'b0;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= {ADDR_W{1'b0}};
          busy    <= 1'b0;
        end
      endcase

      rd_vld_a <= rd_en_a;
      if (rd_en_a) begin
        rd_data_a <= rd_word_a_s;
      end
      rd_vld_b <= rd_en_b;
      if (rd_en_b) begin
        rd_data_b <= rd_word_b_s;
      end
    end
  end

endmodule
